// File: rtl/disp_pkg.sv
// disp_pkg: shared types and constants for the display scan controller
package disp_pkg;
    localparam int DIGITS = 4;
    localparam int BCD_W = 4;
    typedef enum logic [2:0] {IDLE, SNAP, CONV_HI, CONV_LO, COMMIT} state_t;
    typedef logic [1:0] idx_t;
    typedef logic [BCD_W-1:0] bcd_t;
endpackage

// File: rtl/clk_div_tick.sv
// clk_div_tick: free-running 0..DIV-1 counter emitting a one-cycle tick on the wrap cycle
module clk_div_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt;
    assign tick = cnt == W'(DIV - 1);
    // count up, return to zero on the tick cycle
    always_ff @(posedge clk)
        if (!rst_n) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: sequences shared bin2bcd conversions into a tear-free image and scans it onto a 4-digit display
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int UPD_DIV   = 1000000,
    parameter int BLINK_DIV = 50000000,
    parameter bit LZ_BLANK  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic [5:0] alm_hours,
    input  logic [5:0] alm_minutes,
    input  logic       show_alarm,
    input  logic       show_secs,
    input  logic       blink_en,
    output logic [5:0] conv_in,
    input  logic [2:0] conv_tens,
    input  logic [3:0] conv_ones,
    output logic [3:0] digit_bcd,
    output logic [3:0] digit_sel,
    output logic       dp_n,
    output logic       update_done
);
    state_t state, state_nx;
    logic scan_tick, upd_tick, blink_tick;
    logic [5:0] hi_sel, lo_sel, snap_lo;
    logic snap_secs, img_secs, phase, blank;
    bcd_t [DIGITS-1:0] stage, image;
    idx_t idx;

    clk_div_tick #(.DIV(SCAN_DIV))  u_scan  (.clk(clk), .rst_n(rst_n), .tick(scan_tick));
    clk_div_tick #(.DIV(UPD_DIV))   u_upd   (.clk(clk), .rst_n(rst_n), .tick(upd_tick));
    clk_div_tick #(.DIV(BLINK_DIV)) u_blink (.clk(clk), .rst_n(rst_n), .tick(blink_tick));

    assign hi_sel = show_alarm ? alm_hours : show_secs ? minutes : hours;
    assign lo_sel = show_alarm ? alm_minutes : show_secs ? seconds : minutes;
    assign blank = (blink_en && phase) ||
                   (LZ_BLANK && !img_secs && idx == 2'd3 && image[3] == '0);

    // state register
    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    // conversion sequence: tick -> snapshot -> high pair -> low pair -> commit
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = upd_tick ? SNAP : IDLE;
            SNAP:    state_nx = CONV_HI;
            CONV_HI: state_nx = CONV_LO;
            CONV_LO: state_nx = COMMIT;
            default: state_nx = IDLE;
        endcase
    end

    // snapshot operands, stage converter results, commit the whole image at once
    always_ff @(posedge clk)
        if (!rst_n) begin
            conv_in     <= '0;
            snap_lo     <= '0;
            snap_secs   <= 1'b0;
            img_secs    <= 1'b0;
            stage       <= '0;
            image       <= '0;
            update_done <= 1'b0;
        end else begin
            if (state == SNAP) begin
                conv_in   <= hi_sel;
                snap_lo   <= lo_sel;
                snap_secs <= !show_alarm && show_secs;
            end
            if (state == CONV_HI) begin
                stage[3] <= {1'b0, conv_tens};
                stage[2] <= conv_ones;
                conv_in  <= snap_lo;
            end
            if (state == CONV_LO) begin
                stage[1] <= {1'b0, conv_tens};
                stage[0] <= conv_ones;
            end
            if (state == COMMIT) begin
                image    <= stage;
                img_secs <= snap_secs;
            end
            update_done <= state == COMMIT;
        end

    // digit index walks 3->2->1->0 and the blink phase toggles independently of blink_en
    always_ff @(posedge clk)
        if (!rst_n) begin
            idx   <= idx_t'(DIGITS - 1);
            phase <= 1'b0;
        end else begin
            if (scan_tick) idx <= idx - 1'b1;
            if (blink_tick) phase <= !phase;
        end

    // registered drive of anodes, digit value and colon
    always_ff @(posedge clk)
        if (!rst_n) begin
            digit_sel <= 4'b1111;
            digit_bcd <= '0;
            dp_n      <= 1'b1;
        end else begin
            digit_sel <= blank ? 4'b1111 : ~(4'b0001 << idx);
            digit_bcd <= image[idx];
            dp_n      <= !(idx == 2'd2 && !blank);
        end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed and randomized checks of disp_scan_ctrl against a cycle-count model
module tb_disp_scan_ctrl;
    localparam int SCAN = 4, UPD = 16, BLINK = 64;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [5:0] hours, minutes, seconds, alm_hours, alm_minutes, conv_in;
    logic show_alarm, show_secs, blink_en, dp_n, update_done;
    logic [2:0] conv_tens;
    logic [3:0] conv_ones, digit_bcd, digit_sel;
    int checks = 0, passes = 0, k = 0;

    always #5 clk = ~clk;

    assign conv_tens = 3'(conv_in / 10);
    assign conv_ones = 4'(conv_in % 10);

    disp_scan_ctrl #(.SCAN_DIV(SCAN), .UPD_DIV(UPD), .BLINK_DIV(BLINK), .LZ_BLANK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .hours(hours), .minutes(minutes), .seconds(seconds),
        .alm_hours(alm_hours), .alm_minutes(alm_minutes), .show_alarm(show_alarm),
        .show_secs(show_secs), .blink_en(blink_en), .conv_in(conv_in), .conv_tens(conv_tens),
        .conv_ones(conv_ones), .digit_bcd(digit_bcd), .digit_sel(digit_sel), .dp_n(dp_n),
        .update_done(update_done)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: n counts edges since reset release; outputs at edge n come from state after edge n-1.
    int n = 0, mix;
    int img [4];
    logic [5:0] m_hi, m_lo, e_conv;
    logic m_secs, i_secs, e_dp, e_done, mblank;
    logic [3:0] e_sel, e_bcd;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            n = 0;
            img = '{0, 0, 0, 0};
            i_secs = 1'b0;
            e_conv = '0;
            e_sel = 4'hF;
            e_bcd = '0;
            e_dp = 1'b1;
            e_done = 1'b0;
        end else begin
            mix = 3 - (n / SCAN) % 4;
            mblank = (blink_en && (n / BLINK) % 2 == 1) || (!i_secs && mix == 3 && img[3] == 0);
            e_sel = mblank ? 4'hF : 4'(~(4'b0001 << mix));
            e_bcd = 4'(img[mix]);
            e_dp = !(mix == 2 && !mblank);
            n++;
            e_done = 1'b0;
            if (n > UPD && n % UPD == 1) begin
                if (show_alarm) begin m_hi = alm_hours; m_lo = alm_minutes; m_secs = 1'b0; end
                else if (show_secs) begin m_hi = minutes; m_lo = seconds; m_secs = 1'b1; end
                else begin m_hi = hours; m_lo = minutes; m_secs = 1'b0; end
                e_conv = m_hi;
            end
            if (n > UPD && n % UPD == 2) e_conv = m_lo;
            if (n > UPD && n % UPD == 4) begin
                img[3] = m_hi / 10;
                img[2] = m_hi % 10;
                img[1] = m_lo / 10;
                img[0] = m_lo % 10;
                i_secs = m_secs;
                e_done = 1'b1;
            end
        end
        chk("m_conv_in", conv_in, e_conv);
        chk("m_digit_sel", digit_sel, e_sel);
        chk("m_digit_bcd", digit_bcd, e_bcd);
        chk("m_dp_n", dp_n, e_dp);
        chk("m_update_done", update_done, e_done);
    end

    task automatic wait_to(input int t);
        while (k < t) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic first_done(input bit with_conv);
        int first;
        first = -1;
        while (k < 40 && first < 0) begin
            @(negedge clk);
            k++;
            if (with_conv && k == 17) chk("conv_hi_12", conv_in, 12);
            if (with_conv && k == 18) chk("conv_lo_34", conv_in, 34);
            if (update_done) first = k;
        end
        chk("first_done_cycle", first, 20);
    endtask

    task automatic digit(input string name, input int t, input logic [3:0] sel, input logic [3:0] bcd);
        wait_to(t);
        chk({name, "_sel"}, digit_sel, sel);
        chk({name, "_bcd"}, digit_bcd, bcd);
    endtask

    initial begin
        int cnt;
        hours = 12; minutes = 34; seconds = 56; alm_hours = 6; alm_minutes = 30;
        show_alarm = 0; show_secs = 0; blink_en = 0;
        repeat (3) @(negedge clk);
        chk("rst_sel", digit_sel, 4'b1111);
        chk("rst_bcd", digit_bcd, 0);
        chk("rst_dp", dp_n, 1);
        chk("rst_done", update_done, 0);
        chk("rst_conv", conv_in, 0);
        rst_n = 1; k = 0;
        first_done(1'b1);
        digit("basic_d2", 21, 4'b1011, 2);
        chk("basic_colon", dp_n, 0);
        digit("basic_d1", 25, 4'b1101, 3);
        digit("basic_d0", 29, 4'b1110, 4);
        digit("basic_d3", 33, 4'b0111, 1);
        chk("basic_nocolon", dp_n, 1);
        hours = 7; minutes = 5;
        digit("lz_d2", 53, 4'b1011, 7);
        digit("lz_d1", 57, 4'b1101, 0);
        digit("lz_d0", 61, 4'b1110, 5);
        digit("lz_d3", 65, 4'b1111, 0);
        show_secs = 1; minutes = 0; seconds = 9;
        wait_to(96);
        show_secs = 0; hours = 12; minutes = 34;
        digit("secs_d3", 97, 4'b0111, 0);
        minutes = 35;
        digit("snap_d2", 101, 4'b1011, 2);
        digit("snap_old", 109, 4'b1110, 4);
        digit("snap_new", 125, 4'b1110, 5);
        show_alarm = 1; show_secs = 1;
        digit("alm_d2", 133, 4'b1011, 6);
        digit("alm_d1", 137, 4'b1101, 3);
        digit("alm_lz", 145, 4'b1111, 0);
        blink_en = 1;
        wait_to(192);
        cnt = 0;
        repeat (64) begin @(negedge clk); k++; if (digit_sel == 4'hF) cnt++; end
        chk("blink_off_window", cnt, 64);
        cnt = 0;
        repeat (64) begin @(negedge clk); k++; if (digit_sel == 4'hF) cnt++; end
        chk("blink_on_window", cnt, 16);
        blink_en = 0;
        wait_to(322);
        rst_n = 0;
        @(negedge clk);
        chk("midrst_done", update_done, 0);
        chk("midrst_sel", digit_sel, 4'b1111);
        rst_n = 1; k = 0;
        digit("midrst_d3", 1, 4'b1111, 0);
        digit("midrst_clear", 5, 4'b1011, 0);
        first_done(1'b0);
        digit("restart_d2", 21, 4'b1011, 6);
        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) hours = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) minutes = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) seconds = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) alm_hours = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) alm_minutes = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 15) == 0) show_alarm = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) show_secs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 63) == 0) blink_en = 1'($urandom_range(0, 1));
            rst_n = $urandom_range(0, 299) != 0;
        end
        rst_n = 1;
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Time-shares one bin2bcd converter (6-bit in; 3-bit tens, 4-bit ones out) across the alarm clock's time fields.
- Sequences the conversions and keeps a tear-free 4-digit BCD image.
- Scans that image onto a multiplexed common-anode 7-segment display.
- Sits between the timekeeping/alarm registers and the BCD-to-segment decoder.

Parameters:
- SCAN_DIV, 100000: clk cycles each digit stays selected.
- UPD_DIV, 1000000: clk cycles between conversion sequences (refresh of the BCD image).
- BLINK_DIV, 50000000: clk cycles per blink half-period.
- LZ_BLANK, 1: 1 blanks the leading hours-tens digit when it is zero.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- hours  in  6  current hours, 0..23
- minutes  in  6  current minutes, 0..59
- seconds  in  6  current seconds, 0..59
- alm_hours  in  6  alarm hours
- alm_minutes  in  6  alarm minutes
- show_alarm  in  1  1 selects alm_hours:alm_minutes
- show_secs  in  1  1 selects minutes:seconds; show_alarm has priority
- blink_en  in  1  1 blinks the whole display
- conv_in  out  6  operand driven to the shared bin2bcd
- conv_tens  in  3  bin2bcd tens result
- conv_ones  in  4  bin2bcd ones result
- digit_bcd  out  4  BCD value of the currently selected digit
- digit_sel  out  4  anode enables, active-low; bit 3 is the leftmost digit
- dp_n  out  1  decimal point/colon, active-low
- update_done  out  1  one-cycle pulse when a new image is committed

Behaviour:
- Reset: rst_n low at a clk edge forces:
  - FSM to IDLE; all counters to 0
  - image and staging registers d3..d0 to 0
  - conv_in=0, digit_bcd=0, digit_sel=4'b1111, dp_n=1, update_done=0
  - Reset mid-sequence abandons the sequence; no partial commit.
- Update tick: counter counts 0..UPD_DIV-1 and pulses tick on wrap. The first tick occurs UPD_DIV cycles after reset release.
- FSM states:
  - IDLE: wait for tick → SNAP.
  - SNAP: register hi/lo operands and the mode.
    - show_alarm=1: alm_hours / alm_minutes.
    - else show_secs=1: minutes / seconds.
    - else: hours / minutes.
    - → CONV_HI.
  - CONV_HI: conv_in=snap_hi; at the end of the cycle, stage d3={1'b0,conv_tens}, d2=conv_ones → CONV_LO.
  - CONV_LO: conv_in=snap_lo; stage d1, d0 the same way → COMMIT.
  - COMMIT: copy staging to the image registers, update_done=1 for this cycle → IDLE.
- Latency: the image changes exactly 4 cycles after the tick; inputs changing after SNAP do not affect that image.
- A tick arriving while not in IDLE is dropped. This cannot happen when UPD_DIV>=5, and UPD_DIV>=5 is required.
- conv_in holds its last value in IDLE/SNAP/COMMIT. The converter is combinational, so the result is valid in the same cycle.
- Out-of-range inputs (60..63) are converted as-is (e.g. 63 → 6,3); no clamping.
- Scan:
  - Divider counts 0..SCAN_DIV-1; on wrap, digit index idx advances 3→2→1→0→3.
  - The first idx after reset is 3.
  - Outputs are registered: digit_sel = ~(1<<idx), digit_bcd = image[idx], both updated on the cycle after an idx change.
- Blanking: digit_sel is forced to 4'b1111 when either condition holds:
  - blink_en=1 and the blink phase is high. The phase toggles every BLINK_DIV cycles, starts low after reset, and runs even when blink_en=0.
  - LZ_BLANK=1, the committed mode is hours:minutes (or alarm), idx=3 and d3==0. Leading-zero blanking never applies in minutes:seconds mode.
- Colon: dp_n=0 when idx==2 and the digit is not blanked, else 1.
- Mode inputs changing between ticks take effect only at the next SNAP.

Decomposition:
- Shared package disp_pkg:
  - FSM state enum: IDLE, SNAP, CONV_HI, CONV_LO, COMMIT
  - digit index type (2 bits)
  - constant DIGITS=4 and BCD digit width 4
- One natural sub-module: clk_div_tick (parameter DIV, outputs a one-cycle tick), instantiated three times for scan, update and blink.
- bin2bcd remains external; it is instanced at the parent level and wired through conv_in/conv_tens/conv_ones.

Test Plan:
Bench parameters: SCAN_DIV=4, UPD_DIV=16, BLINK_DIV=64, with a real bin2bcd attached.
- Reset: hold rst_n=0 for 3 cycles with inputs nonzero → digit_sel=1111, digit_bcd=0, dp_n=1, update_done=0; first update_done exactly 20 cycles after release.
- Basic: hours=12, minutes=34 → conv_in sequence 12 then 34; after update_done, scanning yields digit_sel 0111/1011/1101/1110 with digit_bcd 1/2/3/4, and dp_n=0 only on 1011.
- Leading zero: hours=7, minutes=5, LZ_BLANK=1 → digit 3 slot shows digit_sel=1111; digits read 7, 0, 5. With show_secs=1, minutes=0, seconds=9 → digit 3 is shown with value 0.
- Snapshot: change minutes from 34 to 35 in the cycle after SNAP → committed image still 1234; next update gives 1235.
- Modes/blink: show_alarm=1 and show_secs=1 with alm 6:30 → image 0630 with alarm priority; blink_en=1 → all anodes off for 64-cycle windows alternating with 64-cycle on windows.
- Reset mid-op: assert rst_n=0 during CONV_LO → no update_done, image=0000, FSM restarts cleanly afterwards.
